// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcodes, ALU-op classes and the control bundle
// carried from decode into the ID/EX register.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef struct packed {
        logic       regDst;
        logic       branch;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic [1:0] aluOp;
        logic       zeroExt;
    } ctrlBundle_t;

    // Unknown opcodes fall through to an all-zero bundle, i.e. a NOP.
    function automatic ctrlBundle_t decodeOpcode(input logic [5:0] opcode);
        ctrlBundle_t c;
        c = '0;
        unique case (opcode)
            OP_RTYPE: begin c.regDst = 1'b1; c.regWrite = 1'b1; c.aluOp = ALUOP_FUNCT; end
            OP_LW:    begin c.aluSrc = 1'b1; c.memRead = 1'b1; c.memToReg = 1'b1;
                            c.regWrite = 1'b1; c.aluOp = ALUOP_ADD; end
            OP_SW:    begin c.aluSrc = 1'b1; c.memWrite = 1'b1; c.aluOp = ALUOP_ADD; end
            OP_BEQ:   begin c.branch = 1'b1; c.aluOp = ALUOP_SUB; end
            OP_ADDI:  begin c.aluSrc = 1'b1; c.regWrite = 1'b1; c.aluOp = ALUOP_ADD; end
            OP_ANDI,
            OP_ORI:   begin c.aluSrc = 1'b1; c.regWrite = 1'b1; c.aluOp = ALUOP_LOGIC;
                            c.zeroExt = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two async read ports, one clocked write port, $0 hardwired
// to zero and same-cycle write-through to the read ports.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rdAddrA,
    input  logic [REG_ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0]     rdDataA,
    output logic [DATA_W-1:0]     rdDataB,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0]     wrData
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wrAddr != '0) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Bypass lets the decoding instruction see a writeback landing this same edge.
    always_comb begin
        rdDataA = regs[rdAddrA];
        if (rdAddrA == '0)                    rdDataA = '0;
        else if (we && wrAddr == rdAddrA)     rdDataA = wrData;
        rdDataB = regs[rdAddrB];
        if (rdAddrB == '0)                    rdDataB = '0;
        else if (we && wrAddr == rdAddrB)     rdDataB = wrData;
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: control decode, register read, immediate extension and
// load-use hazard detection feeding a registered ID/EX boundary.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [31:0]           if_pc,
    input  logic [31:0]           if_instr,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [31:0]           ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_dst,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op
);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rsIdx, rtIdx, rdIdx;
    logic [15:0]           imm16;
    logic [DATA_W-1:0]     rsData, rtData, immExt;
    ctrlBundle_t           ctrl;
    logic                  usesRt, loadUse, loadEn;

    assign opcode = if_instr[31:26];
    assign rsIdx  = if_instr[21 +: REG_ADDR_W];
    assign rtIdx  = if_instr[16 +: REG_ADDR_W];
    assign rdIdx  = if_instr[11 +: REG_ADDR_W];
    assign imm16  = if_instr[15:0];
    assign ctrl   = decodeOpcode(opcode);

    assign immExt = ctrl.zeroExt ? {{(DATA_W-16){1'b0}}, imm16}
                                 : {{(DATA_W-16){imm16[15]}}, imm16};

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .rdAddrA(rsIdx),
        .rdAddrB(rtIdx),
        .rdDataA(rsData),
        .rdDataB(rtData),
        .we     (wb_we),
        .wrAddr (wb_reg),
        .wrData (wb_data)
    );

    // Only R-type, sw and beq actually read rt as a source operand.
    assign usesRt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign loadUse = ex_valid && ex_mem_read && (ex_rt != '0) && if_valid &&
                     ((ex_rt == rsIdx) || (usesRt && (ex_rt == rtIdx)));
    assign id_stall = loadUse;

    // Valid/stall contract: ID/EX captures the IF/ID instruction only when if_valid
    // is high and neither flush nor stall is active; otherwise a zeroed bubble loads
    // and the fetch side must hold IF/ID (stall) or redirect it (flush) that cycle.
    assign loadEn = if_valid && !ex_flush && !loadUse;

    always_ff @(posedge clk) begin
        if (reset || !loadEn) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_dst    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= 2'b00;
        end else begin
            ex_valid      <= 1'b1;
            ex_pc         <= if_pc;
            ex_rs_data    <= rsData;
            ex_rt_data    <= rtData;
            ex_imm        <= immExt;
            ex_rs         <= rsIdx;
            ex_rt         <= rtIdx;
            ex_rd         <= rdIdx;
            ex_reg_dst    <= ctrl.regDst;
            ex_branch     <= ctrl.branch;
            ex_mem_read   <= ctrl.memRead;
            ex_mem_to_reg <= ctrl.memToReg;
            ex_mem_write  <= ctrl.memWrite;
            ex_alu_src    <= ctrl.aluSrc;
            ex_reg_write  <= ctrl.regWrite;
            ex_alu_op     <= ctrl.aluOp;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: hand-computed vectors checked with
// immediate assertions one cycle after each instruction is presented.
module tb_decode_stage_pipe;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]  ex_alu_op;

    int nTests = 0;
    int nFail  = 0;

    decode_stage_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .wb_we        (wb_we),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .ex_flush     (ex_flush),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_reg_dst   (ex_reg_dst),
        .ex_branch    (ex_branch),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write (ex_mem_write),
        .ex_alu_src   (ex_alu_src),
        .ex_reg_write (ex_reg_write),
        .ex_alu_op    (ex_alu_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        if_valid = v;
        if_pc    = pc;
        if_instr = instr;
    endtask

    task automatic writeback(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_we   = we;
        wb_reg  = r;
        wb_data = d;
    endtask

    // Packs {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}.
    function automatic logic [31:0] ctrlVec();
        return {23'd0, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
                ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
    endfunction

    initial begin
        reset = 1'b1;
        ex_flush = 1'b0;
        present(1'b0, 32'd0, 32'd0);
        writeback(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_ctrl", ctrlVec(), 32'd0);
        reset = 1'b0;

        // Preload r1=5, r2=7.
        writeback(1'b1, 5'd1, 32'd5);
        tick();
        writeback(1'b1, 5'd2, 32'd7);
        tick();
        writeback(1'b0, 5'd0, 32'd0);

        // add $3,$1,$2
        present(1'b1, 32'h104, 32'h00221820);
        tick();
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_pc", ex_pc, 32'h104);
        chk("add_rs_data", ex_rs_data, 32'd5);
        chk("add_rt_data", ex_rt_data, 32'd7);
        chk("add_rd", {27'd0, ex_rd}, 32'd3);
        chk("add_ctrl", ctrlVec(), 32'b1_0_0_0_0_0_1_10);

        // lw $4,-4($1)
        present(1'b1, 32'h108, 32'h8C24FFFC);
        tick();
        chk("lw_imm", ex_imm, 32'hFFFFFFFC);
        chk("lw_ctrl", ctrlVec(), 32'b0_0_1_1_0_1_1_00);
        chk("lw_rt", {27'd0, ex_rt}, 32'd4);
        chk("lw_rs_data", ex_rs_data, 32'd5);

        // ori $5,$0,0x8000 (rs=$0, so no hazard against the lw on $4)
        present(1'b1, 32'h10C, 32'h34058000);
        #1;
        chk("ori_no_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("ori_imm", ex_imm, 32'h00008000);
        chk("ori_ctrl", ctrlVec(), 32'b0_0_0_0_0_1_1_11);
        chk("ori_rs_data", ex_rs_data, 32'd0);

        // Same-cycle writeback of $1 while decoding add $3,$1,$2
        present(1'b1, 32'h110, 32'h00221820);
        writeback(1'b1, 5'd1, 32'h000000AA);
        tick();
        chk("bypass_rs_data", ex_rs_data, 32'h000000AA);
        chk("bypass_rt_data", ex_rt_data, 32'd7);

        // Writeback to $0 must never be visible; add $3,$0,$1
        present(1'b1, 32'h114, 32'h00011820);
        writeback(1'b1, 5'd0, 32'h000000FF);
        tick();
        chk("r0_bypass", ex_rs_data, 32'd0);
        chk("r1_stored", ex_rt_data, 32'h000000AA);
        writeback(1'b0, 5'd0, 32'd0);
        tick();
        chk("r0_stored", ex_rs_data, 32'd0);

        // lw $2,0($1) followed by add $3,$2,$2: one stall, one bubble
        present(1'b1, 32'h118, 32'h8C220000);
        tick();
        chk("lw2_mem_read", {31'd0, ex_mem_read}, 32'd1);
        present(1'b1, 32'h11C, 32'h00421820);
        writeback(1'b1, 5'd2, 32'h00000033);
        #1;
        chk("hazard_stall", {31'd0, id_stall}, 32'd1);
        tick();
        writeback(1'b0, 5'd0, 32'd0);
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_ctrl", ctrlVec(), 32'd0);
        chk("bubble_rs_data", ex_rs_data, 32'd0);
        chk("stall_released", {31'd0, id_stall}, 32'd0);
        tick();
        chk("issue_valid", {31'd0, ex_valid}, 32'd1);
        chk("issue_pc", ex_pc, 32'h11C);
        chk("issue_rs_data", ex_rs_data, 32'h00000033);
        chk("issue_rt_data", ex_rt_data, 32'h00000033);
        chk("issue_ctrl", ctrlVec(), 32'b1_0_0_0_0_0_1_10);

        // lw $2 followed by addi $2,$1,1: addi does not read rt, so no stall
        present(1'b1, 32'h120, 32'h8C220000);
        tick();
        present(1'b1, 32'h124, 32'h20220001);
        #1;
        chk("addi_rt_no_stall", {31'd0, id_stall}, 32'd0);

        // lw $2 followed by sw $2,8($1): sw reads rt, so stall; flush overrides it
        present(1'b1, 32'h124, 32'hAC220008);
        ex_flush = 1'b1;
        #1;
        chk("flush_stall_flag", {31'd0, id_stall}, 32'd1);
        tick();
        ex_flush = 1'b0;
        chk("flush_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_bubble_ctrl", ctrlVec(), 32'd0);

        // Fetch redirected to addi $6,$1,-1
        present(1'b1, 32'h200, 32'h2026FFFF);
        #1;
        chk("target_no_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("target_pc", ex_pc, 32'h200);
        chk("target_imm", ex_imm, 32'hFFFFFFFF);
        chk("target_rt", {27'd0, ex_rt}, 32'd6);
        chk("target_ctrl", ctrlVec(), 32'b0_0_0_0_0_1_1_00);

        // beq $1,$2,3
        present(1'b1, 32'h204, 32'h10220003);
        tick();
        chk("beq_ctrl", ctrlVec(), 32'b0_1_0_0_0_0_0_01);
        chk("beq_imm", ex_imm, 32'd3);

        // andi $7,$1,0xF0F0 zero-extends
        present(1'b1, 32'h208, 32'h3027F0F0);
        tick();
        chk("andi_imm", ex_imm, 32'h0000F0F0);
        chk("andi_ctrl", ctrlVec(), 32'b0_0_0_0_0_1_1_11);

        // Unknown opcode (j) decodes as NOP but stays valid
        present(1'b1, 32'h20C, 32'h08000010);
        tick();
        chk("nop_valid", {31'd0, ex_valid}, 32'd1);
        chk("nop_ctrl", ctrlVec(), 32'd0);

        // if_valid low loads a bubble
        present(1'b0, 32'h210, 32'h00221820);
        tick();
        chk("invalid_bubble", {31'd0, ex_valid}, 32'd0);

        // Mid-stream reset clears the pipeline register and the register file
        present(1'b1, 32'h214, 32'h00221820);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", {31'd0, ex_valid}, 32'd0);
        chk("midreset_ctrl", ctrlVec(), 32'd0);
        chk("midreset_pc", ex_pc, 32'd0);
        tick();
        chk("postreset_valid", {31'd0, ex_valid}, 32'd1);
        chk("postreset_rs_data", ex_rs_data, 32'd0);
        chk("postreset_rt_data", ex_rt_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised MIPS instruction-decode stage with an integrated ID/EX pipeline register.
- Contains the main control decoder, a bypassing register file and a sign/zero extender.
- Adds load-use hazard detection with stall/bubble insertion and a flush input for branch resolution.
- Sits between the IF/ID register and the execute stage; all EX-side outputs are registered.

Parameters:
DATA_W, 32, register/datapath width (instruction width fixed at 32)
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
REG_ADDR_W, 5, register index width = log2(NUM_REGS)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_pc  in  32  PC+4 of decoding instruction
if_instr  in  32  instruction word
wb_we  in  1  writeback enable
wb_reg  in  REG_ADDR_W  writeback destination
wb_data  in  DATA_W  writeback data
ex_flush  in  1  kill instruction entering EX (taken branch)
id_stall  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX holds a valid instruction
ex_pc  out  32  registered if_pc
ex_rs_data, ex_rt_data  out  DATA_W  registered operands
ex_imm  out  DATA_W  registered extended immediate
ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered fields [25:21],[20:16],[15:11] (low REG_ADDR_W bits)
ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1  registered control
ex_alu_op  out  2  registered ALU op class

Behaviour:
- Reset (sync, on clk edge with reset=1): all ex_* outputs 0, all registers 0; reset overrides flush/stall/write.
- Latency: one cycle from if_instr to ex_* outputs.
- Decode (opcode [31:26]): R-type 0x00 → reg_dst=1, reg_write=1, alu_op=10. lw 0x23 → alu_src, mem_read, mem_to_reg, reg_write, alu_op=00. sw 0x2B → alu_src, mem_write, alu_op=00. beq 0x04 → branch, alu_op=01. addi 0x08 → alu_src, reg_write, alu_op=00. andi 0x0C / ori 0x0D → alu_src, reg_write, alu_op=11, zero-extend. Any other opcode → all controls 0 (NOP), ex_valid still follows if_valid.
- Immediate: sign-extend [15:0] to DATA_W; zero-extend for andi/ori.
- Register file: NUM_REGS x DATA_W, two async read ports, one write port on posedge when wb_we=1.
  - Register 0 reads 0; writes to it are ignored.
  - Write-through: if wb_we and wb_reg==read index (nonzero), the read returns wb_data in the same cycle.
- Load-use hazard, combinational: ex_valid & ex_mem_read & ex_rt!=0 & if_valid & (ex_rt==rs, or ex_rt==rt for R-type/sw/beq) → id_stall=1.
  - On the next edge a bubble loads: ex_valid=0, all ex control 0, data fields don't-care (drive 0).
- Flush: ex_flush=1 loads a bubble on the next edge regardless of the stall condition.
  - id_stall is still driven per the hazard rule; the fetch side gives flush priority.
- Priority at edge: reset > flush > stall > normal load. if_valid=0 → bubble.
- Simultaneous writeback + hazard: register write still happens during a stall.

Decomposition:
- Package decode_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI), ALU-op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_LOGIC=11), and a packed control-bundle struct.
- Sub-module regfile_bypass (params DATA_W, NUM_REGS, REG_ADDR_W; sync reset clear, write-through, $0 hardwired).
- Control decode and hazard logic stay inline.

Test Plan:
- Reset then add $3,$1,$2 (0x00221820) with r1=5, r2=7 preloaded via wb → next cycle: ex_valid=1, ex_rs_data=5, ex_rt_data=7, ex_rd=3, reg_dst=1, alu_op=10.
- lw $4,-4($1) (0x8C24FFFC) → ex_imm=0xFFFFFFFC, mem_read=1, mem_to_reg=1, alu_src=1; ori $5,$0,0x8000 → ex_imm=0x00008000, alu_op=11.
- Same-cycle wb_we=1, wb_reg=1, wb_data=0xAA while decoding add using $1 → ex_rs_data=0xAA; wb to $0 with 0xFF → later read of $0 =0.
- lw $2,0($1) then add $3,$2,$2 → id_stall=1 for exactly one cycle, one bubble (ex_valid=0, controls 0), add issues the following cycle.
- ex_flush=1 during a stall cycle → bubble loaded, no duplicate instruction; reset asserted mid-stream → all ex_* =0 next edge and registers read 0.
